// File: rtl/dlsc_pcie_pkg.sv
// Shared definitions for the Spartan-6 PCIe receive router.
//   - TYPE_*  : 5-bit TLP type codes, bits [28:24] of the first header dword.
//               Codes with a don't-care LSB (MEM, CFG, CPL) or don't-care
//               low three bits (MSG) list the lowest member of the group.
//   - state_t : router FSM encodings.
//   - classify: maps a TLP type to the path that TLP must take.
package dlsc_pcie_pkg;

    localparam logic [4:0] TYPE_MEM = 5'b00000;  // 0000x: MRd / MRdLk / MWr
    localparam logic [4:0] TYPE_IO  = 5'b00010;  // IORd / IOWr
    localparam logic [4:0] TYPE_CFG = 5'b00100;  // 0010x: Cfg0 / Cfg1
    localparam logic [4:0] TYPE_CPL = 5'b01010;  // 0101x: Cpl / CplD / CplLk / CplDLk
    localparam logic [4:0] TYPE_MSG = 5'b10000;  // 10xxx: Msg / MsgD

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CPL  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // Destination of a TLP, expressed as the FSM state that carries it.
    function automatic state_t classify(input logic [4:0] tlp_type, input logic msg_to_req);
        state_t dest;
        dest = ST_DROP;
        if ((tlp_type[4:1] == TYPE_MEM[4:1]) || (tlp_type == TYPE_IO) ||
            (tlp_type[4:1] == TYPE_CFG[4:1])) begin
            dest = ST_REQ;
        end else if (tlp_type[4:1] == TYPE_CPL[4:1]) begin
            dest = ST_CPL;
        end else if (tlp_type[4:3] == TYPE_MSG[4:3]) begin
            dest = msg_to_req ? ST_REQ : ST_DROP;
        end
        return dest;
    endfunction

endpackage

// File: rtl/dlsc_pcie_rx_slot.sv
// Single-entry registered output slot with a valid/ready handshake.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid_i              load the beat presented on in_* this cycle
//   in_data_i/last/err/bar  beat payload
//   can_accept_o            slot is empty or its beat leaves this cycle
//   out_ready_i             downstream takes the current beat
//   out_valid_o/data/last/err/bar  registered beat towards downstream
// The caller must only raise in_valid_i while can_accept_o is high.
module dlsc_pcie_rx_slot
    import dlsc_pcie_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    input  logic        in_last_i,
    input  logic        in_err_i,
    input  logic [6:0]  in_bar_i,
    output logic        can_accept_o,
    input  logic        out_ready_i,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    output logic        out_last_o,
    output logic        out_err_o,
    output logic [6:0]  out_bar_o
);

    logic        valid_q, valid_d;
    logic [31:0] data_q;
    logic        last_q;
    logic        err_q;
    logic [6:0]  bar_q;

    // Draining and refilling in the same cycle keeps full throughput.
    assign can_accept_o = ~valid_q | out_ready_i;

    always_comb begin
        valid_d = valid_q;
        if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
        if (in_valid_i) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            bar_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (in_valid_i) begin
                data_q <= in_data_i;
                last_q <= in_last_i;
                err_q  <= in_err_i;
                bar_q  <= in_bar_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign out_err_o   = err_q;
    assign out_bar_o   = bar_q;

endmodule

// File: rtl/dlsc_pcie_s6_rx_router.sv
// Spartan-6 PCIe receive router. Classifies each TLP from the core's 32-bit
// trn_r* stream on its first dword and forwards it whole to the inbound
// request port (rx_*), the outbound completion port (cpl_*), or discards it.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   trn_r*               core receive stream (active-low controls)
//   trn_rdst_rdy_n       beat accepted by the router (active low)
//   trn_rnp_ok_n         registered ~rx_np_ok back to the core
//   rx_*                 request port: valid/ready, data, last, err, bar
//   cpl_*                completion port: valid/ready, data, last, err
//   cnt_drop             saturating count of discarded TLPs
//   cnt_proto            saturating count of framing errors
module dlsc_pcie_s6_rx_router
    import dlsc_pcie_pkg::*;
#(
    parameter int CNT_BITS   = 16,
    parameter bit MSG_TO_REQ = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trn_rsof_n,
    input  logic                trn_reof_n,
    input  logic [31:0]         trn_rd,
    input  logic                trn_rerrfwd_n,
    input  logic                trn_rsrc_rdy_n,
    output logic                trn_rdst_rdy_n,
    input  logic [6:0]          trn_rbar_hit_n,
    output logic                trn_rnp_ok_n,
    input  logic                rx_np_ok,
    input  logic                rx_ready,
    output logic                rx_valid,
    output logic                rx_last,
    output logic                rx_err,
    output logic [31:0]         rx_data,
    output logic [6:0]          rx_bar,
    input  logic                cpl_ready,
    output logic                cpl_valid,
    output logic                cpl_last,
    output logic                cpl_err,
    output logic [31:0]         cpl_data,
    output logic [CNT_BITS-1:0] cnt_drop,
    output logic [CNT_BITS-1:0] cnt_proto
);

    state_t              state_q, state_d;
    logic [6:0]          bar_q, bar_d;
    logic                rst_done_q;
    logic                np_ok_n_q;
    logic [CNT_BITS-1:0] cnt_drop_q, cnt_drop_d;
    logic [CNT_BITS-1:0] cnt_proto_q, cnt_proto_d;

    logic        beat_vld, beat_sof, beat_eof, beat_err;
    state_t      sof_dest;
    logic        req_can, cpl_can, dest_can, path_can;
    logic        beat_ready, beat_fire;
    logic        req_load, cpl_load;
    logic [31:0] ld_data;
    logic        ld_last, ld_err;
    logic [6:0]  ld_bar;
    logic        drop_inc, proto_inc;
    logic [6:0]  cpl_bar_unused;

    assign beat_vld = ~trn_rsrc_rdy_n;
    assign beat_sof = ~trn_rsof_n;
    assign beat_eof = ~trn_reof_n;
    assign beat_err = ~trn_rerrfwd_n;

    assign sof_dest = classify(trn_rd[28:24], MSG_TO_REQ);

    // Whether the destination of a SOF beat can take it; DROP always can.
    always_comb begin
        dest_can = 1'b1;
        if (sof_dest == ST_REQ) begin
            dest_can = req_can;
        end else if (sof_dest == ST_CPL) begin
            dest_can = cpl_can;
        end
    end

    assign path_can = (state_q == ST_CPL) ? cpl_can : req_can;

    // Ready towards the core. A SOF inside an open REQ/CPL TLP is never
    // taken directly: the open TLP is closed first, then the SOF is
    // classified from IDLE on the following cycle. rst_done_q keeps the
    // core stalled during and right after reset.
    always_comb begin
        beat_ready = 1'b0;
        case (state_q)
            ST_IDLE, ST_DROP: beat_ready = beat_sof ? dest_can : 1'b1;
            ST_REQ, ST_CPL:   beat_ready = ~beat_sof & path_can;
            default:          beat_ready = 1'b0;
        endcase
        beat_ready = beat_ready & rst_done_q;
    end

    assign beat_fire      = beat_ready & beat_vld;
    assign trn_rdst_rdy_n = ~beat_ready;

    always_comb begin
        state_d   = state_q;
        bar_d     = bar_q;
        req_load  = 1'b0;
        cpl_load  = 1'b0;
        ld_data   = trn_rd;
        ld_last   = beat_eof;
        ld_err    = beat_err;
        ld_bar    = bar_q;
        drop_inc  = 1'b0;
        proto_inc = 1'b0;
        case (state_q)
            ST_IDLE, ST_DROP: begin
                if (beat_fire) begin
                    if (beat_sof) begin
                        bar_d     = ~trn_rbar_hit_n;
                        ld_bar    = ~trn_rbar_hit_n;
                        // SOF inside a dropped TLP is still a framing error.
                        proto_inc = (state_q == ST_DROP);
                        if (sof_dest == ST_REQ) begin
                            req_load = 1'b1;
                        end else if (sof_dest == ST_CPL) begin
                            cpl_load = 1'b1;
                        end else begin
                            drop_inc = 1'b1;
                        end
                        state_d = beat_eof ? ST_IDLE : sof_dest;
                    end else if (state_q == ST_IDLE) begin
                        // Beat outside any TLP: swallowed.
                        proto_inc = 1'b1;
                    end else if (beat_eof) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REQ, ST_CPL: begin
                if (beat_vld && beat_sof) begin
                    // Close the open TLP with an empty errored last beat.
                    if (path_can) begin
                        ld_data   = '0;
                        ld_last   = 1'b1;
                        ld_err    = 1'b1;
                        req_load  = (state_q == ST_REQ);
                        cpl_load  = (state_q == ST_CPL);
                        proto_inc = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (beat_fire) begin
                    req_load = (state_q == ST_REQ);
                    cpl_load = (state_q == ST_CPL);
                    if (beat_eof) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_drop_d  = cnt_drop_q;
        cnt_proto_d = cnt_proto_q;
        if (drop_inc && (cnt_drop_q != {CNT_BITS{1'b1}})) begin
            cnt_drop_d = cnt_drop_q + CNT_BITS'(1);
        end
        if (proto_inc && (cnt_proto_q != {CNT_BITS{1'b1}})) begin
            cnt_proto_d = cnt_proto_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bar_q       <= '0;
            rst_done_q  <= 1'b0;
            np_ok_n_q   <= 1'b1;
            cnt_drop_q  <= '0;
            cnt_proto_q <= '0;
        end else begin
            state_q     <= state_d;
            bar_q       <= bar_d;
            rst_done_q  <= 1'b1;
            np_ok_n_q   <= ~rx_np_ok;
            cnt_drop_q  <= cnt_drop_d;
            cnt_proto_q <= cnt_proto_d;
        end
    end

    assign trn_rnp_ok_n = np_ok_n_q;
    assign cnt_drop     = cnt_drop_q;
    assign cnt_proto    = cnt_proto_q;

    dlsc_pcie_rx_slot u_req_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (req_load),
        .in_data_i    (ld_data),
        .in_last_i    (ld_last),
        .in_err_i     (ld_err),
        .in_bar_i     (ld_bar),
        .can_accept_o (req_can),
        .out_ready_i  (rx_ready),
        .out_valid_o  (rx_valid),
        .out_data_o   (rx_data),
        .out_last_o   (rx_last),
        .out_err_o    (rx_err),
        .out_bar_o    (rx_bar)
    );

    // Completions carry no BAR; the slot's copy is left unused.
    dlsc_pcie_rx_slot u_cpl_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (cpl_load),
        .in_data_i    (ld_data),
        .in_last_i    (ld_last),
        .in_err_i     (ld_err),
        .in_bar_i     (ld_bar),
        .can_accept_o (cpl_can),
        .out_ready_i  (cpl_ready),
        .out_valid_o  (cpl_valid),
        .out_data_o   (cpl_data),
        .out_last_o   (cpl_last),
        .out_err_o    (cpl_err),
        .out_bar_o    (cpl_bar_unused)
    );

endmodule
